// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, frame FSM state type and the
// odd-parity helper for the PS/2 keyboard arrow receiver.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchroniser, glitch filter and falling-edge strobe for
// the PS/2 clock line. The filtered level only changes after FILTER_LEN
// consecutive synchronised samples that disagree with it. SYNC_STAGES >= 2.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic line_raw,
  output logic fall
);

  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   filt_r;
  logic                   fall_r;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign fall   = fall_r;

  // Synchroniser chain; preset to the idle-high line level.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], line_raw};
    end
  end

  // Glitch filter: count disagreeing samples, flip after FILTER_LEN in a row,
  // and pulse fall for the one cycle in which the level drops to 0.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cnt_r  <= '0;
      filt_r <= 1'b1;
      fall_r <= 1'b0;
    end else if (sync_s != filt_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= '0;
        filt_r <= sync_s;
        fall_r <= ~sync_s;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        fall_r <= 1'b0;
      end
    end else begin
      cnt_r  <= '0;
      fall_r <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_kbd_arrow_rx.sv
// ps2_kbd_arrow_rx: PS/2 device-to-host frame receiver with E0/F0 prefix
// tracking and four level "held" flags for the cursor keys.
// Optional macro PS2_NUMPAD_ARROWS_EN: when defined, non-extended keypad
// 8/2/4/6 codes drive the same arrow flags as the extended cursor keys.
module ps2_kbd_arrow_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 56750
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_err,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right
);

  import ps2_pkg::*;

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_NUMPAD_ARROWS_EN
  localparam logic NUMPAD_EN = 1'b1;
`else
  localparam logic NUMPAD_EN = 1'b0;
`endif

  logic                   clk_fall_s;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   data_s;

  frame_state_t           state_r;
  frame_state_t           next_state_s;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             sr_r;
  logic                   parity_r;
  logic [TO_W-1:0]        to_cnt_r;

  logic                   timeout_s;
  logic                   frame_done_s;
  logic                   frame_ok_s;

  logic [7:0]             code_r;
  logic                   code_valid_r;
  logic                   code_err_r;
  logic                   ext_r;
  logic                   brk_r;
  logic                   key_up_r;
  logic                   key_down_r;
  logic                   key_left_r;
  logic                   key_right_r;
  logic                   arrow_en_s;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .line_raw (ps2_clk),
    .fall     (clk_fall_s)
  );

  // Data line only needs synchronising: it is stable around the clock fall.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      data_sync_r <= '1;
    end else begin
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Frame FSM state register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame FSM next state: advances on clock falls, timeout abandons a frame.
  always_comb begin
    next_state_s = state_r;
    if (timeout_s) begin
      next_state_s = IDLE;
    end else if (clk_fall_s) begin
      case (state_r)
        IDLE: begin
          if (!data_s) begin
            next_state_s = DATA;
          end else begin
            next_state_s = IDLE;
          end
        end
        DATA: begin
          if (bit_cnt_r == 3'd7) begin
            next_state_s = PARITY;
          end else begin
            next_state_s = DATA;
          end
        end
        PARITY:  next_state_s = STOP;
        STOP:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Frame FSM outputs: frame completion, frame check and timeout decision.
  always_comb begin
    frame_done_s = clk_fall_s && (state_r == STOP);
    frame_ok_s   = data_s && odd_parity_ok(sr_r, parity_r);
    timeout_s    = (state_r != IDLE) && !clk_fall_s && (to_cnt_r == TO_LAST);
  end

  // Bit shifting and parity capture on each clock fall.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      bit_cnt_r <= 3'd0;
      sr_r      <= 8'h00;
      parity_r  <= 1'b0;
    end else if (clk_fall_s) begin
      case (state_r)
        IDLE: begin
          bit_cnt_r <= 3'd0;
        end
        DATA: begin
          sr_r      <= {data_s, sr_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        PARITY: begin
          parity_r <= data_s;
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Inter-edge timeout counter; idle and every clock fall restart it.
  always_ff @(posedge vga_clk) begin
    if (reset || (state_r == IDLE) || clk_fall_s) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_LAST) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Registered frame result: code held until the next good frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      code_r       <= 8'h00;
      code_valid_r <= 1'b0;
      code_err_r   <= 1'b0;
    end else begin
      code_valid_r <= frame_done_s && frame_ok_s;
      code_err_r   <= frame_done_s && !frame_ok_s;
      if (frame_done_s && frame_ok_s) begin
        code_r <= sr_r;
      end else begin
        code_r <= code_r;
      end
    end
  end

  assign arrow_en_s = ext_r || NUMPAD_EN;

  // Prefix tracking and arrow make/break decoding on each accepted code.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      key_up_r    <= 1'b0;
      key_down_r  <= 1'b0;
      key_left_r  <= 1'b0;
      key_right_r <= 1'b0;
    end else if (code_valid_r) begin
      if (code_r == SC_EXT) begin
        ext_r <= 1'b1;
      end else if (code_r == SC_BRK) begin
        brk_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
        if (arrow_en_s) begin
          case (code_r)
            SC_UP:    key_up_r    <= !brk_r;
            SC_DOWN:  key_down_r  <= !brk_r;
            SC_LEFT:  key_left_r  <= !brk_r;
            SC_RIGHT: key_right_r <= !brk_r;
            default:  key_up_r    <= key_up_r;
          endcase
        end else begin
          key_up_r <= key_up_r;
        end
      end
    end else if (code_err_r) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else begin
      ext_r <= ext_r;
    end
  end

  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign code_err   = code_err_r;
  assign key_up     = key_up_r;
  assign key_down   = key_down_r;
  assign key_left   = key_left_r;
  assign key_right  = key_right_r;

endmodule

// File: tb/tb_ps2_kbd_arrow_rx.sv
// tb_ps2_kbd_arrow_rx: directed PS/2 frame stimulus with a scoreboard of
// expected codes/errors consumed by a strobe monitor.
module tb_ps2_kbd_arrow_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 100;

  typedef struct {
    logic       err;
    logic [7:0] code;
  } exp_t;

  logic       vga_clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       code_err;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;

  int         errors;
  int         checks;
  int         valid_cnt;
  int         valid_base;
  logic [7:0] last_code;
  logic       prev_strobe;
  exp_t       sb_q[$];
  exp_t       e;

  ps2_kbd_arrow_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .code_err   (code_err),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right)
  );

  initial vga_clk = 1'b0;
  always #18 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic check_flags(input string tag, input logic u, input logic d,
                             input logic l, input logic r);
    chk({tag, "_up"}, key_up, u);
    chk({tag, "_down"}, key_down, d);
    chk({tag, "_left"}, key_left, l);
    chk({tag, "_right"}, key_right, r);
  endtask

  // One bit cell: data set while clock is high, then a low half period.
  // With glitch set, a FILTER_LEN-1 cycle pulse is injected in each half.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2 - (FILTER_LEN - 1));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_cyc(HALF / 2);
      ps2_clk = 1'b1;
      wait_cyc(FILTER_LEN - 1);
      ps2_clk = 1'b0;
      wait_cyc(HALF / 2 - (FILTER_LEN - 1));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  // Send the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] d, input bit bad, input bit glitch, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^d);
    if (bad) par = ~par;
    fr = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad, input bit glitch);
    exp_t x;
    x.err  = bad;
    x.code = d;
    sb_q.push_back(x);
    send_bits(d, bad, glitch, 11);
    wait_cyc(3 * HALF);
  endtask

  // Scoreboard monitor: every strobe pops one expectation.
  always @(negedge vga_clk) begin
    if (!reset && (code_valid || code_err)) begin
      chk("pulse_width", prev_strobe, 1'b0);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, code_valid, code_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_err", code_err, e.err);
        chk("strobe_valid", code_valid, !e.err);
        if (e.err) begin
          chk("code_held", code, last_code);
        end else begin
          chk("code", code, e.code);
          last_code = e.code;
        end
      end
    end
    if (code_valid) valid_cnt++;
    prev_strobe = code_valid | code_err;
  end

  initial begin
    errors      = 0;
    checks      = 0;
    valid_cnt   = 0;
    last_code   = 8'h00;
    prev_strobe = 1'b0;
    reset       = 1'b1;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    wait_cyc(5);
    chk("rst_code", code, 8'h00);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_err", code_err, 1'b0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wait_cyc(20);

    // Plain code 1C.
    send_frame(8'h1C, 1'b0, 1'b0);
    check_flags("after_1c", 1'b0, 1'b0, 1'b0, 1'b0);

    // Extended up make then release.
    send_frame(8'hE0, 1'b0, 1'b0);
    check_flags("after_e0", 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_flags("up_make", 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_flags("up_pending", 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_flags("up_break", 1'b0, 1'b0, 1'b0, 1'b0);

    // Parity error, then extended right still decodes.
    send_frame(8'h33, 1'b1, 1'b0);
    chk("err_code_held", code, 8'h75);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check_flags("right_make", 1'b0, 1'b0, 1'b0, 1'b1);

    // Short glitches on the clock line must not shift extra bits.
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("glitch_code", code, 8'h5A);

    // Partial frame abandoned by timeout, then a full frame.
    send_bits(8'hA5, 1'b0, 1'b0, 5);
    wait_cyc(TIMEOUT + 1000);
    chk("partial_code", code, 8'h5A);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("after_timeout_code", code, 8'h29);

    // Keypad arrow codes: only affect flags with the numpad option.
    valid_base = valid_cnt;
    send_frame(8'h6B, 1'b0, 1'b0);
`ifdef PS2_NUMPAD_ARROWS_EN
    check_flags("kp_make", 1'b0, 1'b0, 1'b1, 1'b1);
`else
    check_flags("kp_make", 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    check_flags("kp_break", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("kp_valid_count", valid_cnt - valid_base, 3);

    // Reset in mid-frame: flags clear, no strobe.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_flags("pre_reset", 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(8'h3C, 1'b0, 1'b0, 5);
    reset = 1'b1;
    wait_cyc(3);
    check_flags("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_code", code, 8'h00);
    last_code = 8'h00;
    reset = 1'b0;
    wait_cyc(TIMEOUT + 200);
    send_frame(8'h11, 1'b0, 1'b0);
    chk("post_reset_code", code, 8'h11);
    check_flags("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_arrow_rx.md
Name: ps2_kbd_arrow_rx

Overview:
- PS/2 keyboard receiver and arrow-key decoder in the vga_clk domain.
- Deserialises device-to-host frames, checks them, and presents each accepted scan code on a one-cycle strobe.
- Tracks E0/F0 prefixes and keeps four level "held" flags for the cursor keys.
- Directly upstream of the VGA test-pattern/sprite stage, which consumes the up/down/left/right flags once per frame.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on ps2_clk and ps2_data (minimum 2).
- FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples needed before the filtered clock changes.
- TIMEOUT_CYCLES, 56750, vga_clk cycles (about 2 ms) without a filtered falling edge before a partial frame is discarded.

Ports:
- vga_clk  in  1  system clock, 28.375 MHz nominal.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from the pad, asynchronous.
- ps2_data  in  1  raw PS/2 data from the pad, asynchronous.
- code  out  8  last accepted scan code; held until the next accepted code.
- code_valid  out  1  one-cycle strobe, code is new.
- code_err  out  1  one-cycle strobe on a parity or stop-bit error.
- key_up  out  1  extended 75 held.
- key_down  out  1  extended 72 held.
- key_left  out  1  extended 6B held.
- key_right  out  1  extended 74 held.
- Clock/reset (already decided): reset is synchronous, active-high; clock is vga_clk.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; the ext and brk prefix flags are 0; the filtered clock and synchroniser flops are preset to 1.
- Input conditioning:
  - Both inputs pass through SYNC_STAGES flops.
  - The filtered clock takes the new level only after FILTER_LEN identical consecutive samples.
  - A falling edge (filtered 1 then 0) produces a one-cycle fall strobe.
  - Data is sampled from the synchronised ps2_data on the fall strobe.
- Frame FSM, advancing only on fall strobes:
  - IDLE: a start bit of 0 goes to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift LSB first, shift register {bit, sr[7:1]}. After the 8th bit go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: the frame is good if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity). Return to IDLE either way.
- Output latency: code and code_valid are updated in the cycle after the stop-bit fall strobe. On a bad frame, code_err pulses in that same cycle, code is unchanged and code_valid stays 0.
- Timeout:
  - The counter resets on every fall strobe and while in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM returns to IDLE.
  - No strobe is emitted on timeout; ext and brk are unchanged.
- Decoder, acting on code_valid:
  - E0 sets ext.
  - F0 sets brk.
  - Any other code, with ext=1 and code in {75,72,6B,74}: the matching flag becomes !brk.
  - After any non-prefix code, ext and brk clear.
  - Non-extended codes never change the arrow flags (unless the optional feature is enabled).
  - code_err clears ext and brk; the arrow flags are kept.
- Sequencing cases:
  - E0 F0 75 releases up.
  - F0 E0 75 is also accepted as a release (prefix order independent).
  - Repeated make codes (typematic repeat) leave a flag at 1.
  - Several arrow flags may be 1 at the same time; the consumer resolves conflicts.
- Reset mid-frame: reset aborts the frame immediately with no strobe, and all flags clear.

Optional Feature:
- Macro: PS2_NUMPAD_ARROWS_EN.
- Defined: non-extended 75/72/6B/74 (keypad 8/2/4/6, NumLock off) drive the same arrow flags under the same make/break rule.
- Undefined: only E0-prefixed codes affect the arrow flags; keypad codes are reported on code/code_valid only.

Decomposition:
- Package ps2_pkg:
  - Scan-code constants SC_EXT=E0, SC_BRK=F0, SC_UP=75, SC_DOWN=72, SC_LEFT=6B, SC_RIGHT=74.
  - Frame FSM state enum (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_line_filter: synchroniser plus glitch filter plus fall-strobe generator. The top level instantiates it once for the clock path; the data path uses the synchroniser only.

Test Plan:
- Frame for 1C (bits 0,00111000 LSB first, parity 0, stop 1) at 12.5 kHz -> code=1C and code_valid for exactly 1 cycle; no code_err.
- Frames E0,75 then E0,F0,75 -> key_up rises after the 2nd frame and falls after the 5th; the other three flags stay 0.
- Frame with parity flipped -> code_err for 1 cycle, code still holds its previous value, no code_valid. A following E0 then 74 frame still sets key_right.
- Glitches of FILTER_LEN-1 cycles on ps2_clk in mid-frame -> no extra bit shifted; code equals the transmitted value.
- Send 5 bits of a frame, pause 3 ms, then a full frame for 29 -> no strobe for the partial frame; code=29 is accepted.
- With PS2_NUMPAD_ARROWS_EN: frames 6B then F0,6B -> key_left goes 1 then 0. Without the macro: key_left stays 0 and code_valid pulses 3 times.
